// File: rtl/aud_codec_pkg.sv
// Shared defaults and types for the audio codec serial port.
package aud_codec_pkg;

   localparam int AUD_DATA_W = 16;
   localparam int AUD_SLOT_W = 32;

   typedef logic [AUD_DATA_W-1:0] sample_t;

   typedef enum logic {
      CH_LEFT  = 1'b0,
      CH_RIGHT = 1'b1
   } chan_e;

endpackage

// File: rtl/aud_bclk_gen.sv
// Bit-clock divider: o_bclk has a period of 2*BCLK_DIV i_clk cycles.
// o_fall/o_rise are high in the cycle before o_bclk toggles, so registers
// that update on them change on the same edge as o_bclk.
module aud_bclk_gen #(
   parameter int BCLK_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_bclk,
   output logic o_fall,
   output logic o_rise
);

   localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

   logic [DIV_W-1:0] r_div;
   logic             r_bclk;
   logic             w_tc;

   assign w_tc = (r_div == DIV_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_div  <= '0;
         r_bclk <= 1'b0;
      end else if (w_tc) begin
         r_div  <= '0;
         r_bclk <= ~r_bclk;
      end else begin
         r_div  <= r_div + 1'b1;
      end
   end

   assign o_bclk = r_bclk;
   assign o_fall = w_tc & r_bclk;
   assign o_rise = w_tc & ~r_bclk;

endmodule

// File: rtl/aud_codec_port.sv
// I2S codec port: serialises parallel ADC samples and deserialises DAC frames.
// Optional macro AUD_CODEC_PORT_LOOPBACK_EN adds i_loopback (DAC -> ADC path).
module aud_codec_port
   import aud_codec_pkg::*;
#(
   parameter int BCLK_DIV = 4,
   parameter int DATA_W   = AUD_DATA_W,
   parameter int SLOT_W   = AUD_SLOT_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
`ifdef AUD_CODEC_PORT_LOOPBACK_EN
   input  logic              i_loopback,
`endif
   output logic              o_bclk,
   output logic              o_lrck,
   output logic              o_adcdat,
   input  logic              i_dacdat,
   input  logic [DATA_W-1:0] i_adc_l,
   input  logic [DATA_W-1:0] i_adc_r,
   output logic              o_adc_req,
   output logic [DATA_W-1:0] o_dac_l,
   output logic [DATA_W-1:0] o_dac_r,
   output logic              o_dac_valid
);

   localparam int K_W = $clog2(SLOT_W);
   localparam logic [K_W-1:0] K_LAST = K_W'(SLOT_W - 1);
   localparam logic [K_W-1:0] K_DATA = K_W'(DATA_W);

   logic              w_fall, w_rise, w_wrap, w_lrck_next, w_tx_en, w_rx_en;
   logic [K_W-1:0]    w_k_next;
   logic [DATA_W-1:0] w_ld_l, w_ld_r;
   chan_e             w_ch_next;

   logic [K_W-1:0]    r_k;
   logic              r_lrck, r_adcdat, r_adc_req, r_dac_valid;
   logic [DATA_W-1:0] r_tx_l, r_tx_r, r_rx_l, r_rx_r, r_dac_l, r_dac_r;

   aud_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .o_bclk (o_bclk),
      .o_fall (w_fall),
      .o_rise (w_rise)
   );

`ifdef AUD_CODEC_PORT_LOOPBACK_EN
   assign w_ld_l = i_loopback ? r_dac_l : i_adc_l;
   assign w_ld_r = i_loopback ? r_dac_r : i_adc_r;
`else
   assign w_ld_l = i_adc_l;
   assign w_ld_r = i_adc_r;
`endif

   assign w_wrap      = (r_k == K_LAST);
   assign w_k_next    = w_wrap ? '0 : r_k + 1'b1;
   assign w_lrck_next = r_lrck ^ w_wrap;
   assign w_ch_next   = w_lrck_next ? CH_RIGHT : CH_LEFT;
   // I2S: one idle bit after the frame-clock edge, then MSB-first data.
   assign w_tx_en     = (w_k_next != '0) && (w_k_next <= K_DATA);
   assign w_rx_en     = (r_k != '0) && (r_k <= K_DATA);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_k         <= K_LAST;
         r_lrck      <= 1'b1;
         r_adcdat    <= 1'b0;
         r_adc_req   <= 1'b0;
         r_dac_valid <= 1'b0;
         r_tx_l      <= '0;
         r_tx_r      <= '0;
         r_rx_l      <= '0;
         r_rx_r      <= '0;
         r_dac_l     <= '0;
         r_dac_r     <= '0;
      end else begin
         r_adc_req   <= 1'b0;
         r_dac_valid <= 1'b0;
         if (r_adc_req) begin
            r_tx_l <= w_ld_l;
            r_tx_r <= w_ld_r;
         end
         if (w_fall) begin
            r_k       <= w_k_next;
            r_lrck    <= w_lrck_next;
            r_adc_req <= w_wrap & r_lrck;
            r_adcdat  <= 1'b0;
            if (w_tx_en) begin
               if (w_ch_next == CH_LEFT) begin
                  r_adcdat <= r_tx_l[DATA_W-1];
                  r_tx_l   <= {r_tx_l[DATA_W-2:0], 1'b0};
               end else begin
                  r_adcdat <= r_tx_r[DATA_W-1];
                  r_tx_r   <= {r_tx_r[DATA_W-2:0], 1'b0};
               end
            end
         end
         // Reset parks k at the end of a right slot, so no partial frame can complete.
         if (w_rise && w_rx_en) begin
            if (r_lrck == CH_LEFT) begin
               r_rx_l <= {r_rx_l[DATA_W-2:0], i_dacdat};
            end else begin
               r_rx_r <= {r_rx_r[DATA_W-2:0], i_dacdat};
               if (r_k == K_DATA) begin
                  r_dac_l     <= r_rx_l;
                  r_dac_r     <= {r_rx_r[DATA_W-2:0], i_dacdat};
                  r_dac_valid <= 1'b1;
               end
            end
         end
      end
   end

   assign o_lrck      = r_lrck;
   assign o_adcdat    = r_adcdat;
   assign o_adc_req   = r_adc_req;
   assign o_dac_l     = r_dac_l;
   assign o_dac_r     = r_dac_r;
   assign o_dac_valid = r_dac_valid;

endmodule

// File: tb/tb_aud_codec_port.sv
// Directed bench for aud_codec_port at default parameters (BCLK_DIV=4, 16/32).
module tb_aud_codec_port;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        o_bclk, o_lrck, o_adcdat, i_dacdat, o_adc_req, o_dac_valid;
   logic [15:0] i_adc_l, i_adc_r, o_dac_l, o_dac_r;
`ifdef AUD_CODEC_PORT_LOOPBACK_EN
   logic        i_loopback;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aud_codec_port dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
`ifdef AUD_CODEC_PORT_LOOPBACK_EN
      .i_loopback  (i_loopback),
`endif
      .o_bclk      (o_bclk),
      .o_lrck      (o_lrck),
      .o_adcdat    (o_adcdat),
      .i_dacdat    (i_dacdat),
      .i_adc_l     (i_adc_l),
      .i_adc_r     (i_adc_r),
      .o_adc_req   (o_adc_req),
      .o_dac_l     (o_dac_l),
      .o_dac_r     (o_dac_r),
      .o_dac_valid (o_dac_valid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one full 512-cycle frame starting in an o_adc_req cycle and ends
   // in the following o_adc_req cycle. Cycle 8p is the fall into slot position p.
   task automatic run_frame(input logic [15:0] dl, input logic [15:0] dr,
                            input int chg_cyc, input logic [15:0] chg_val,
                            output logic [31:0] cap_l, output logic [31:0] cap_r,
                            output int nvalid, output int vcyc,
                            output logic [15:0] got_l, output logic [15:0] got_r,
                            output int nreq);
      int pos, k, ch;
      cap_l = '0; cap_r = '0; nvalid = 0; vcyc = -1; got_l = '0; got_r = '0; nreq = 0;
      for (int cyc = 0; cyc < 512; cyc++) begin
         if (cyc > 0) tick();
         pos = cyc / 8;
         k   = pos % 32;
         ch  = pos / 32;
         if (cyc % 8 == 0) begin
            if (ch == 0) cap_l[31-k] = o_adcdat;
            else         cap_r[31-k] = o_adcdat;
            if (k >= 1 && k <= 16) i_dacdat = (ch == 0) ? dl[16-k] : dr[16-k];
            else                   i_dacdat = 1'b0;
            checks++;
            if (o_lrck !== ch[0]) begin
               errors++;
               $display("FAIL frame_lrck cyc %0d: got %b expected %b", cyc, o_lrck, ch[0]);
            end
            checks++;
            if (o_bclk !== 1'b0) begin
               errors++;
               $display("FAIL frame_bclk_low cyc %0d: got %b expected 0", cyc, o_bclk);
            end
         end
         if (cyc % 8 == 4) begin
            checks++;
            if (o_bclk !== 1'b1) begin
               errors++;
               $display("FAIL frame_bclk_high cyc %0d: got %b expected 1", cyc, o_bclk);
            end
         end
         if (cyc == chg_cyc) i_adc_l = chg_val;
         if (o_dac_valid === 1'b1) begin
            nvalid++;
            vcyc  = cyc;
            got_l = o_dac_l;
            got_r = o_dac_r;
         end
         if (cyc > 0 && o_adc_req === 1'b1) nreq++;
      end
      tick();
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      repeat (3) tick();
      checks++; if (o_bclk !== 1'b0)      begin errors++; $display("FAIL rst_bclk: got %b expected 0", o_bclk); end
      checks++; if (o_lrck !== 1'b1)      begin errors++; $display("FAIL rst_lrck: got %b expected 1", o_lrck); end
      checks++; if (o_adcdat !== 1'b0)    begin errors++; $display("FAIL rst_adcdat: got %b expected 0", o_adcdat); end
      checks++; if (o_adc_req !== 1'b0)   begin errors++; $display("FAIL rst_adc_req: got %b expected 0", o_adc_req); end
      checks++; if (o_dac_valid !== 1'b0) begin errors++; $display("FAIL rst_dac_valid: got %b expected 0", o_dac_valid); end
      checks++; if (o_dac_l !== 16'h0)    begin errors++; $display("FAIL rst_dac_l: got %h expected 0000", o_dac_l); end
      checks++; if (o_dac_r !== 16'h0)    begin errors++; $display("FAIL rst_dac_r: got %h expected 0000", o_dac_r); end
      i_rst = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         tick();
         checks++;
         if (o_bclk !== ((n >= 4 && n <= 7) ? 1'b1 : 1'b0)) begin
            errors++; $display("FAIL release_bclk edge %0d: got %b", n, o_bclk);
         end
         checks++;
         if (o_adc_req !== ((n == 8) ? 1'b1 : 1'b0)) begin
            errors++; $display("FAIL release_adc_req edge %0d: got %b", n, o_adc_req);
         end
         checks++;
         if (o_lrck !== ((n == 8) ? 1'b0 : 1'b1)) begin
            errors++; $display("FAIL release_lrck edge %0d: got %b", n, o_lrck);
         end
      end
   endtask

   task automatic test_adc_format();
      logic [31:0] cl, cr;
      logic [15:0] gl, gr;
      int nv, vc, nr;
      run_frame(16'h8000, 16'h7FFF, -1, 16'h0, cl, cr, nv, vc, gl, gr, nr);
      checks++; if (cl !== {1'b0, 16'hA5C3, 15'h0}) begin errors++; $display("FAIL adc_left_bits: got %h expected %h", cl, {1'b0, 16'hA5C3, 15'h0}); end
      checks++; if (cr !== {1'b0, 16'h0001, 15'h0}) begin errors++; $display("FAIL adc_right_bits: got %h expected %h", cr, {1'b0, 16'h0001, 15'h0}); end
      checks++; if (nr !== 0)          begin errors++; $display("FAIL adc_req_in_frame: got %0d expected 0", nr); end
      checks++; if (o_adc_req !== 1'b1) begin errors++; $display("FAIL adc_req_period: got %b expected 1", o_adc_req); end
   endtask

   task automatic test_dac_stream();
      logic [31:0] cl, cr;
      logic [15:0] gl, gr;
      int nv, vc, nr;
      for (int f = 0; f < 2; f++) begin
         run_frame(16'h8000, 16'h7FFF, -1, 16'h0, cl, cr, nv, vc, gl, gr, nr);
         checks++; if (nv !== 1)        begin errors++; $display("FAIL dac_valid_count f%0d: got %0d expected 1", f, nv); end
         checks++; if (vc !== 388)      begin errors++; $display("FAIL dac_valid_cycle f%0d: got %0d expected 388", f, vc); end
         checks++; if (gl !== 16'h8000) begin errors++; $display("FAIL dac_l f%0d: got %h expected 8000", f, gl); end
         checks++; if (gr !== 16'h7FFF) begin errors++; $display("FAIL dac_r f%0d: got %h expected 7fff", f, gr); end
      end
      checks++; if (o_dac_l !== 16'h8000) begin errors++; $display("FAIL dac_l_hold: got %h expected 8000", o_dac_l); end
   endtask

   task automatic test_adc_midchange();
      logic [31:0] cl, cr;
      logic [15:0] gl, gr;
      int nv, vc, nr;
      i_adc_l = 16'h1234;
      run_frame(16'h0F0F, 16'hF0F0, 100, 16'hFFFF, cl, cr, nv, vc, gl, gr, nr);
      checks++; if (cl !== {1'b0, 16'h1234, 15'h0}) begin errors++; $display("FAIL midchange_cur: got %h expected %h", cl, {1'b0, 16'h1234, 15'h0}); end
      checks++; if (gl !== 16'h0F0F || gr !== 16'hF0F0) begin errors++; $display("FAIL midchange_dac: got %h/%h expected 0f0f/f0f0", gl, gr); end
      run_frame(16'h0F0F, 16'hF0F0, -1, 16'h0, cl, cr, nv, vc, gl, gr, nr);
      checks++; if (cl !== {1'b0, 16'hFFFF, 15'h0}) begin errors++; $display("FAIL midchange_next: got %h expected %h", cl, {1'b0, 16'hFFFF, 15'h0}); end
      checks++; if (cr !== {1'b0, 16'h0001, 15'h0}) begin errors++; $display("FAIL midchange_right: got %h expected %h", cr, {1'b0, 16'h0001, 15'h0}); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] cl, cr;
      logic [15:0] gl, gr;
      int nv, vc, nr, early;
      early = 0;
      i_dacdat = 1'b1;
      for (int cyc = 1; cyc <= 322; cyc++) begin
         tick();
         if (o_dac_valid === 1'b1) early++;
      end
      i_rst = 1'b1;
      tick();
      checks++; if (o_bclk !== 1'b0)      begin errors++; $display("FAIL midrst_bclk: got %b expected 0", o_bclk); end
      checks++; if (o_lrck !== 1'b1)      begin errors++; $display("FAIL midrst_lrck: got %b expected 1", o_lrck); end
      checks++; if (o_adcdat !== 1'b0)    begin errors++; $display("FAIL midrst_adcdat: got %b expected 0", o_adcdat); end
      checks++; if (o_adc_req !== 1'b0)   begin errors++; $display("FAIL midrst_adc_req: got %b expected 0", o_adc_req); end
      checks++; if (o_dac_valid !== 1'b0) begin errors++; $display("FAIL midrst_dac_valid: got %b expected 0", o_dac_valid); end
      checks++; if (o_dac_l !== 16'h0 || o_dac_r !== 16'h0) begin errors++; $display("FAIL midrst_dac: got %h/%h expected 0000/0000", o_dac_l, o_dac_r); end
      tick();
      i_rst = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         tick();
         if (o_dac_valid === 1'b1) early++;
      end
      checks++; if (early !== 0)        begin errors++; $display("FAIL midrst_early_valid: got %0d expected 0", early); end
      checks++; if (o_adc_req !== 1'b1) begin errors++; $display("FAIL midrst_restart_req: got %b expected 1", o_adc_req); end
      run_frame(16'h1357, 16'h2468, -1, 16'h0, cl, cr, nv, vc, gl, gr, nr);
      checks++; if (nv !== 1 || vc !== 388) begin errors++; $display("FAIL midrst_valid: got %0d at %0d expected 1 at 388", nv, vc); end
      checks++; if (gl !== 16'h1357 || gr !== 16'h2468) begin errors++; $display("FAIL midrst_dac_data: got %h/%h expected 1357/2468", gl, gr); end
      checks++; if (cl !== {1'b0, 16'hFFFF, 15'h0}) begin errors++; $display("FAIL midrst_adc: got %h expected %h", cl, {1'b0, 16'hFFFF, 15'h0}); end
   endtask

`ifdef AUD_CODEC_PORT_LOOPBACK_EN
   task automatic test_loopback();
      logic [31:0] cl, cr;
      logic [15:0] gl, gr;
      int nv, vc, nr;
      i_loopback = 1'b1;
      run_frame(16'hABCD, 16'h4321, -1, 16'h0, cl, cr, nv, vc, gl, gr, nr);
      run_frame(16'h0000, 16'h0000, -1, 16'h0, cl, cr, nv, vc, gl, gr, nr);
      checks++; if (cl !== {1'b0, 16'hABCD, 15'h0}) begin errors++; $display("FAIL loopback_left: got %h expected %h", cl, {1'b0, 16'hABCD, 15'h0}); end
      checks++; if (cr !== {1'b0, 16'h4321, 15'h0}) begin errors++; $display("FAIL loopback_right: got %h expected %h", cr, {1'b0, 16'h4321, 15'h0}); end
      i_loopback = 1'b0;
   endtask
`endif

   initial begin
      i_rst    = 1'b1;
      i_dacdat = 1'b0;
      i_adc_l  = 16'hA5C3;
      i_adc_r  = 16'h0001;
`ifdef AUD_CODEC_PORT_LOOPBACK_EN
      i_loopback = 1'b0;
`endif
      test_reset();
      test_adc_format();
      test_dac_stream();
      test_adc_midchange();
      test_reset_mid();
`ifdef AUD_CODEC_PORT_LOOPBACK_EN
      test_loopback();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
